// File: rtl/sipo_frame_pkg.sv
// Shared definitions for the serial word receiver: FSM state encoding and counter sizing.
// No logic; types and constant functions only.
// Imported by sipo_frame_rx and sipo_shift_nbit.
package sipo_frame_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width for an n-bit word; the counter only ever holds 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_shift_nbit.sv
// N-bit LSB-first shift register: new bits enter at the MSB, load_first restarts a word.
// Latency: one cycle to the register; shreg_nxt exposes the value being written this edge.
// No backpressure; the controller decides when bits are taken.
module sipo_shift_nbit
  import sipo_frame_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         ser_in,
  input  logic         shift_en,
  input  logic         load_first,
  output logic [N-1:0] shreg_nxt
);

  logic [N-1:0] shreg;

  // Next-value mux: restart with bit 0 at the MSB, shift right, or hold.
  always_comb begin
    shreg_nxt = shreg;
    if (load_first) begin
      shreg_nxt = {ser_in, {(N-1){1'b0}}};
    end else if (shift_en) begin
      shreg_nxt = {ser_in, shreg[N-1:1]};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      shreg <= '0;
    end else begin
      shreg <= shreg_nxt;
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-in parallel-out word receiver with sync-marker resync and a held output word.
// Latency: par_vld_out rises the cycle after bit N-1 is sampled; one word per N valid bits.
// Backpressure: an unaccepted word is held; a word completing while it is held is dropped and sets ovr_out.
module sipo_frame_rx
  import sipo_frame_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         ser_in,
  input  logic         ser_vld_in,
  input  logic         sync_in,
  output logic [N-1:0] par_out,
  output logic         par_vld_out,
  input  logic         par_rdy_in,
  output logic         ovr_out,
  output logic         sync_err_out,
  input  logic         clr_in
);

  localparam int CW = cnt_w(N);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          shift_en;
  logic          load_first;
  logic          complete;
  logic          sync_err_nxt;
  logic [N-1:0]  shreg_nxt;

  sipo_shift_nbit #(.N(N)) u_shift (
    .clk        (clk),
    .reset_al_in(reset_al_in),
    .ser_in     (ser_in),
    .shift_en   (shift_en),
    .load_first (load_first),
    .shreg_nxt  (shreg_nxt)
  );

  // FSM state and bit counter registers.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a sync bit always starts a word (discarding any partial one); bit N-1 completes it.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shift_en     = 1'b0;
    load_first   = 1'b0;
    complete     = 1'b0;
    sync_err_nxt = 1'b0;
    if (ser_vld_in) begin
      case (state)
        IDLE: begin
          if (sync_in) begin
            load_first = 1'b1;
            cnt_nxt    = CW'(1);
            state_nxt  = SHIFT;
          end
        end
        SHIFT: begin
          if (sync_in) begin
            load_first   = 1'b1;
            cnt_nxt      = CW'(1);
            sync_err_nxt = 1'b1;
          end else if (cnt == CW'(N-1)) begin
            shift_en  = 1'b1;
            complete  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            shift_en = 1'b1;
            cnt_nxt  = cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output word register: load when free or being accepted this cycle, otherwise flag overrun.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      par_out      <= '0;
      par_vld_out  <= 1'b0;
      ovr_out      <= 1'b0;
      sync_err_out <= 1'b0;
    end else begin
      sync_err_out <= sync_err_nxt;
      if (complete) begin
        if (!par_vld_out || par_rdy_in) begin
          par_out     <= shreg_nxt;
          par_vld_out <= 1'b1;
        end
      end else if (par_vld_out && par_rdy_in) begin
        par_vld_out <= 1'b0;
      end
      // Set takes priority over clear so an overrun coinciding with clr_in is not lost.
      if (complete && par_vld_out && !par_rdy_in) begin
        ovr_out <= 1'b1;
      end else if (clr_in) begin
        ovr_out <= 1'b0;
      end
    end
  end

endmodule
